// File: rtl/sequence_player.sv
// Colour-sequence player: fetches colour codes from a sequence memory and
// lights one of four LEDs per item, with a fixed dark gap between items.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet
// S_FETCH | one-cycle read strobe at mem_addr = index
// S_LOAD  | memory data returns; capture colour, load on-time into timer
// S_ON    | selected LED lit until the timer reaches zero
// S_GAP   | all LEDs dark for GAP_CYCLES, then next item or finish
// S_DONE  | one-cycle done pulse, then back to idle
module sequence_player #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 2,
   parameter int ON_SLOW    = 8,
   parameter int ON_FAST    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  speed,
   input  logic [ADDR_WIDTH:0]   seq_len,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  led_red,
   output logic                  led_green,
   output logic                  led_blue,
   output logic                  led_yellow,
   output logic                  busy,
   output logic                  done
);

   localparam int T_MAX0 = (ON_SLOW > ON_FAST) ? ON_SLOW : ON_FAST;
   localparam int T_MAX  = (T_MAX0 > GAP_CYCLES) ? T_MAX0 : GAP_CYCLES;
   localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   localparam logic [TW-1:0] ON_SLOW_TC = TW'(ON_SLOW - 1);
   localparam logic [TW-1:0] ON_FAST_TC = TW'(ON_FAST - 1);
   localparam logic [TW-1:0] GAP_TC     = TW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_ON, S_GAP, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   index_q, index_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic                    speed_q, speed_d;
   logic [DATA_WIDTH-1:0]   colour_q, colour_d;
   logic [TW-1:0]           timer_q, timer_d;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         len_q    <= '0;
         speed_q  <= 1'b0;
         colour_q <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         len_q    <= len_d;
         speed_q  <= speed_d;
         colour_q <= colour_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state and datapath updates; timer counts down to a zero terminal count.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      len_d    = len_q;
      speed_d  = speed_q;
      colour_d = colour_q;
      timer_d  = timer_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               speed_d = speed;
               len_d   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
               index_d = '0;
               state_d = (seq_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            colour_d = mem_data;
            timer_d  = speed_q ? ON_FAST_TC : ON_SLOW_TC;
            state_d  = S_ON;
         end
         S_ON: begin
            if (timer_q == '0) begin
               timer_d = GAP_TC;
               state_d = S_GAP;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               if ({1'b0, index_q} == len_q - LEN_ONE) begin
                  state_d = S_DONE;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything once playback has begun.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   // Moore outputs decoded from the current state and colour register.
   always_comb begin
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      mem_rd     = (state_q == S_FETCH);
      mem_addr   = index_q;
      led_red    = (state_q == S_ON) && (colour_q == 2'b00);
      led_green  = (state_q == S_ON) && (colour_q == 2'b01);
      led_blue   = (state_q == S_ON) && (colour_q == 2'b10);
      led_yellow = (state_q == S_ON) && (colour_q == 2'b11);
   end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player using a cycle-indexed playback model.
module tb_sequence_player;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       speed;
   logic [5:0] seq_len;
   logic       mem_rd;
   logic [4:0] mem_addr;
   logic [1:0] mem_data;
   logic       led_red, led_green, led_blue, led_yellow;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   logic [1:0] mem [32];

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd;
      logic [3:0] led;
      logic [4:0] addr;
      logic       chk_addr;
   } exp_t;

   sequence_player dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .speed     (speed),
      .seq_len   (seq_len),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .led_red   (led_red),
      .led_green (led_green),
      .led_blue  (led_blue),
      .led_yellow(led_yellow),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data valid the cycle after the address is presented.
   always @(posedge clk) mem_data <= mem[mem_addr];

   // Expected outputs at cycle c after the start cycle (cycle 0), for n items
   // of on cycles each: every item is fetch, load, on-time, two gap cycles.
   function automatic exp_t model(int c, int n, int on);
      exp_t e;
      int   per, total, k, r;
      e = '0;
      if (n == 0) begin
         if (c == 1) begin
            e.busy = 1'b1; e.done = 1'b1; e.addr = 5'd0; e.chk_addr = 1'b1;
         end
         return e;
      end
      per   = 2 + on + 2;
      total = n * per;
      if (c >= 1 && c <= total) begin
         k = (c - 1) / per;
         r = (c - 1) % per;
         e.busy = 1'b1;
         e.addr = 5'(k);
         e.chk_addr = 1'b1;
         if (r == 0) e.rd = 1'b1;
         else if (r >= 2 && r <= on + 1) e.led = 4'b1000 >> mem[k];
      end else if (c == total + 1) begin
         e.busy = 1'b1; e.done = 1'b1; e.addr = 5'(n - 1); e.chk_addr = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [6:0] observed();
      return {busy, done, mem_rd, led_red, led_green, led_blue, led_yellow};
   endfunction

   task automatic randomize_mem();
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
   endtask

   // Plays one sequence from the current (idle) cycle, optionally perturbing
   // inputs, holding start, or killing the run with abort or reset at kill_at.
   task automatic run_seq(input int len_in, input bit spd, input bit perturb,
                          input bit hold, input int kill_at, input bit kill_rst);
      int   n, on, total, last;
      exp_t e;
      n     = (len_in > 32) ? 32 : len_in;
      on    = spd ? 4 : 8;
      total = n * (4 + on);
      last  = (kill_at > 0) ? kill_at : total + 2;
      seq_len = 6'(len_in);
      speed   = spd;
      start   = 1'b1;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         if (!hold) start = 1'b0;
         if (perturb && c <= total) begin
            start   = 1'($urandom);
            speed   = 1'($urandom);
            seq_len = 6'($urandom);
         end
         if (kill_at > 0 && c == kill_at) begin
            if (kill_rst) rst_n = 1'b0;
            else          abort = 1'b1;
         end
         @(negedge clk);
         e = model(c, n, on);
         checks++;
         if (observed() !== {e.busy, e.done, e.rd, e.led}) begin
            failures++;
            $display("FAIL play_outputs n=%0d spd=%0d c=%0d got=%b exp=%b",
                     len_in, spd, c, observed(), {e.busy, e.done, e.rd, e.led});
         end
         if (e.chk_addr) begin
            checks++;
            if (mem_addr !== e.addr) begin
               failures++;
               $display("FAIL play_addr n=%0d c=%0d got=%0d exp=%0d",
                        len_in, c, mem_addr, e.addr);
            end
         end
      end
      if (kill_at > 0) begin
         @(posedge clk); #1;
         rst_n = 1'b1;
         abort = 1'b0;
         start = 1'b0;
         @(negedge clk);
         checks++;
         if (observed() !== 7'b0) begin
            failures++;
            $display("FAIL kill_idle rst=%0d got=%b exp=%b", kill_rst, observed(), 7'b0);
         end
         if (kill_rst) begin
            checks++;
            if (mem_addr !== 5'd0) begin
               failures++;
               $display("FAIL reset_addr got=%0d exp=0", mem_addr);
            end
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               checks++;
               if (mem_rd !== 1'b0 || busy !== 1'b0) begin
                  failures++;
                  $display("FAIL reset_no_restart i=%0d rd=%b busy=%b exp 0 0", i, mem_rd, busy);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; speed = 1'b0; seq_len = 6'd3;
      for (int i = 0; i < 32; i++) mem[i] = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (observed() !== 7'b0 || mem_addr !== 5'd0) begin
         failures++;
         $display("FAIL reset_state got=%b addr=%0d exp=0 addr=0", observed(), mem_addr);
      end
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL reset_needs_start busy=%b rd=%b exp 0 0", busy, mem_rd);
         end
      end
   endtask

   task automatic test_directed();
      mem[0] = 2'b00; mem[1] = 2'b11; mem[2] = 2'b01;
      run_seq(3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      run_seq(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      mem[0] = 2'b10;
      run_seq(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_abort();
      randomize_mem();
      run_seq(3, 1'b1, 1'b0, 1'b0, 5, 1'b0);
      run_seq(3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      // abort outranks start while idle
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_rd !== 1'b0) begin
         failures++;
         $display("FAIL abort_priority busy=%b rd=%b exp 0 0", busy, mem_rd);
      end
   endtask

   task automatic test_reset_mid();
      randomize_mem();
      run_seq(4, 1'b0, 1'b0, 1'b0, 4, 1'b1);
      run_seq(2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_full_length();
      randomize_mem();
      run_seq(32, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      run_seq(63, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_perturb();
      randomize_mem();
      run_seq(3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      run_seq(5, 1'b0, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      randomize_mem();
      run_seq(2, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      run_seq(3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         randomize_mem();
         run_seq(int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_reset_mid();
      test_full_length();
      test_perturb();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, sequence memory address width.
REQ-002 Parameter DATA_WIDTH, default 2, colour code width; fixed at 2.
REQ-003 Parameter ON_SLOW, default 8, LED-on cycles per item when speed=0; minimum 1.
REQ-004 Parameter ON_FAST, default 4, LED-on cycles per item when speed=1; minimum 1.
REQ-005 Parameter GAP_CYCLES, default 2, all-LEDs-off cycles after each item; minimum 1.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 start  in  1  level, sampled only in IDLE; begins playback.
REQ-009 abort  in  1  level; cancels playback from any state.
REQ-010 speed  in  1  0 = slow, 1 = fast; sampled with start.
REQ-011 seq_len  in  ADDR_WIDTH+1  number of items to play; sampled with start.
REQ-012 mem_rd  out  1  read strobe to sequence memory.
REQ-013 mem_addr  out  ADDR_WIDTH  read address.
REQ-014 mem_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd.
REQ-015 led_red, led_green, led_blue, led_yellow  out  1 each  colour LEDs, active-high.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at playback completion.

Function
REQ-018 The block SHALL implement states IDLE, FETCH, LOAD, ON, GAP, DONE.
REQ-019 IDLE: start=1 and abort=0 SHALL latch speed, latch len=min(seq_len, 2^ADDR_WIDTH), clear index, and go to FETCH, or to DONE if seq_len=0.
REQ-020 FETCH: mem_rd=1 and mem_addr=index for exactly one cycle; next state LOAD.
REQ-021 LOAD: capture mem_data into the colour register; load the timer with ON_FAST or ON_SLOW per the latched speed; next state ON.
REQ-022 ON: exactly one LED high per colour register (00 red, 01 green, 10 blue, 11 yellow) for the loaded cycle count; then GAP.
REQ-023 GAP: all LEDs low for GAP_CYCLES cycles; then DONE if index=len-1, else index+1 and FETCH.
REQ-024 DONE: done=1 and busy=1 for one cycle; next state IDLE.
REQ-025 Outside ON, all LEDs SHALL be low; mem_rd SHALL be low outside FETCH; mem_addr SHALL equal index in every state.
REQ-026 Each item SHALL take exactly 2+ON+GAP_CYCLES cycles; consecutive items SHALL have no extra idle cycles.
REQ-027 start SHALL be ignored while busy=1; speed and seq_len changes during playback SHALL have no effect.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle with LEDs low, mem_rd low, and no done pulse; abort SHALL take priority over start in IDLE.
REQ-029 seq_len=2^ADDR_WIDTH SHALL play addresses 0 to 2^ADDR_WIDTH-1 with no wrap; larger values SHALL clamp to that length.
REQ-030 start held high continuously SHALL restart playback on the cycle after DONE returns to IDLE.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE; clear index, timer and colour register; drive mem_rd, busy, done and all LEDs to 0; and set mem_addr=0, regardless of current state.
REQ-032 After reset, the block SHALL require a new start sampled in IDLE before any memory read.

Verification
REQ-033 Memory {0:00, 1:11, 2:01}, seq_len=3, speed=1, start pulsed at cycle 0 -> FETCH at cycles 1, 9, 17; red on cycles 3-6, yellow 11-14, green 19-22; done at cycle 25 only.
REQ-034 seq_len=0, start -> no mem_rd, LEDs stay low, done at cycle 1, busy low from cycle 2.
REQ-035 seq_len=1, speed=0, memory[0]=10 -> blue on 8 cycles (3-10), gap 11-12, done at 13.
REQ-036 seq_len=3, abort at cycle 5 -> IDLE at cycle 6, LEDs low, no done; start at cycle 6 replays from address 0.
REQ-037 Second start during playback, and speed toggled mid-run -> no restart; item timing unchanged.
REQ-038 rst_n low during ON for one cycle -> every output 0 the next cycle; no further mem_rd until a new start.
